acc_c_slv_adapter: RTL and testbench
====================================

# acc_c_slv_adapter

Accelerator-side adapter that terminates one response port of the accelerator C-bus interconnect and drives a single accelerator with an ID-less, strictly in-order request/response handshake. It buffers incoming requests, tracks the extended IDs of issued requests in order, and re-attaches each ID to the matching accelerator response. It also bounds the number of outstanding transactions so the interconnect never blocks on a full accelerator. One instance sits directly downstream of each interconnect slave-side port.

## Interface
Parameters:
- DataWidth, 32, operand/result width
- AddrWidth, 6, C-bus address width
- AccAddrWidth, 4, low address bits that select the accelerator
- IdWidth, 4, extended ID width from the interconnect
- ReqDepth, 2, request FIFO depth (≥1)
- MaxOutstanding, 4, max accepted-but-unanswered requests (≥1)

Ports:
- clk_i  in  1  clock
- rst_n  in  1  reset, asynchronous, active-high
- acc_addr_i  in  AccAddrWidth  this accelerator's address (quasi-static)
- slv_q_addr  in  AddrWidth  request address
- slv_q_id  in  IdWidth  request ID
- slv_q_instr  in  32  offloaded instruction
- slv_q_arg  in  3*DataWidth  operands a,b,c
- slv_q_valid / slv_q_ready  in/out  1  request handshake
- slv_p_data  out  DataWidth  response data
- slv_p_error  out  1  response error
- slv_p_id  out  IdWidth  response ID
- slv_p_valid / slv_p_ready  out/in  1  response handshake
- acc_q_instr  out  32, acc_q_arg  out  3*DataWidth
- acc_q_valid / acc_q_ready  out/in  1  accelerator request handshake
- acc_p_data  in  DataWidth, acc_p_error  in  1
- acc_p_valid / acc_p_ready  in/out  1  accelerator response handshake
- outstanding_o  out  $clog2(MaxOutstanding+1)  current outstanding count
- protocol_err_o  out  1  sticky: accelerator response with no pending ID

## Operation
- slv_q_ready = !req_fifo_full && outstanding < MaxOutstanding.
- Request handshake pushes {addr, id, instr, arg} into request FIFO; outstanding +1.
- FIFO head drives acc_q_*; acc_q_valid = !req_fifo_empty. On acc_q handshake: pop, push {id, local_err=0} into ID FIFO (depth MaxOutstanding; never overflows by construction).
- Accelerator responses are in order. acc_p_ready = !rsp_reg_valid || slv_p_ready, forced 0 when ID FIFO head is absent or has local_err=1.
- On acc_p handshake: rsp_reg ← {acc_p_data, acc_p_error, ID FIFO head id}, pop ID FIFO.
- acc_p_valid with ID FIFO empty: response consumed (acc_p_ready=1), dropped, protocol_err_o set until reset.
- slv_p_* driven from rsp_reg; slv_p handshake clears rsp_reg_valid; outstanding −1. Simultaneous +1/−1: unchanged.
- Reset outputs: slv_q_ready 0, acc_q_valid 0, acc_p_ready 0, slv_p_valid 0, slv_p_data/error/id 0, outstanding_o 0, protocol_err_o 0. Reset mid-operation flushes both FIFOs and rsp_reg; in-flight accelerator work is discarded.

## Timing
- Request: accepted cycle t → acc_q_valid earliest t+1 (registered FIFO, no fall-through).
- Response: acc_p handshake cycle t → slv_p_valid at t+1; full throughput 1/cycle with slv_p_ready held high.
- Full request throughput 1/cycle requires ReqDepth ≥ 2 and acc_q_ready high.
- FIFO full and simultaneous push/pop: push blocked by slv_q_ready (full computed pre-pop); pointers wrap modulo depth.

## Configuration
- ACC_C_SLV_ADAPTER_ADDR_CHECK_EN defined: at FIFO head, if addr[AccAddrWidth-1:0] != acc_addr_i, entry is popped without asserting acc_q_valid and pushed to ID FIFO with local_err=1. When that entry reaches ID FIFO head, rsp_reg is loaded with data 0, error 1, its id, without an acc_p handshake, preserving order.
- Undefined: address ignored, local_err always 0, acc_addr_i unused.

## Structure
- acc_pkg holds request/response/ID-entry struct typedef generators and the outstanding-count width helper.
- One sub-module: acc_adapter_fifo (parameterised width/depth, full/empty, registered output), instanced for request and ID FIFOs.

## Test plan
- Single request id=5, acc_q_ready=1, accelerator responds 3 cycles later with data 0xCAFE → slv_p id=5, data 0xCAFE, error 0, one cycle after acc_p handshake.
- Back-to-back ids 1,2,3,4,5 with accelerator stalled → four accepted, slv_q_ready low with outstanding_o=4; first response re-enables acceptance the cycle after slv_p handshake.
- slv_p_ready held low with two acc responses queued → acc_p_ready low after first; no data loss, ids emitted in order.
- acc_p_valid with no pending request → response dropped, protocol_err_o=1 until rst_n asserted.
- Macro defined, acc_addr_i=3, requests addr 3 (id 1), addr 7 (id 2) → id 1 forwarded; id 2 answered data 0, error 1, strictly after id 1's response.
- rst_n asserted with 3 outstanding → all outputs return to reset values; after release outstanding_o=0 and no stale responses.

Source files
------------

// File: rtl/acc_pkg.sv
// ============================================================================
// Module   : acc_pkg
// Brief    : Shared widths and width helpers for the accelerator C-bus slave adapter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package acc_pkg;

  localparam int unsigned INSTR_W = 32;

  // Width of a counter that must hold 0..max_val inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int unsigned req_width(input int unsigned addr_w,
                                            input int unsigned id_w,
                                            input int unsigned data_w);
    return addr_w + id_w + INSTR_W + 3 * data_w;
  endfunction

  function automatic int unsigned id_entry_width(input int unsigned id_w);
    return id_w + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/acc_adapter_fifo.sv
// ============================================================================
// Module   : acc_adapter_fifo
// Brief    : Register-based FIFO with full/empty flags and no fall-through.
// Revision : 1.0
// ============================================================================
`default_nettype none

module acc_adapter_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == CW'(DEPTH));
  assign empty  = (r_count == '0);
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign rdata  = r_mem[r_rptr];

  always_ff @(posedge clk_i or posedge rst_n) begin
    if (rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + PW'(1);
      if (w_pop)  r_rptr <= (r_rptr == PW'(DEPTH - 1)) ? '0 : r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= wdata;
  end

endmodule

`default_nettype wire

// File: rtl/acc_c_slv_adapter.sv
// ============================================================================
// Module   : acc_c_slv_adapter
// Brief    : C-bus slave port to in-order ID-less accelerator bridge; optional
//            address check enabled by ACC_C_SLV_ADAPTER_ADDR_CHECK_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module acc_c_slv_adapter
  import acc_pkg::*;
#(
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned AddrWidth      = 6,
  parameter int unsigned AccAddrWidth   = 4,
  parameter int unsigned IdWidth        = 4,
  parameter int unsigned ReqDepth       = 2,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_n,
  input  logic [AccAddrWidth-1:0]              acc_addr_i,
  input  logic [AddrWidth-1:0]                 slv_q_addr,
  input  logic [IdWidth-1:0]                   slv_q_id,
  input  logic [31:0]                          slv_q_instr,
  input  logic [3*DataWidth-1:0]               slv_q_arg,
  input  logic                                 slv_q_valid,
  output logic                                 slv_q_ready,
  output logic [DataWidth-1:0]                 slv_p_data,
  output logic                                 slv_p_error,
  output logic [IdWidth-1:0]                   slv_p_id,
  output logic                                 slv_p_valid,
  input  logic                                 slv_p_ready,
  output logic [31:0]                          acc_q_instr,
  output logic [3*DataWidth-1:0]               acc_q_arg,
  output logic                                 acc_q_valid,
  input  logic                                 acc_q_ready,
  input  logic [DataWidth-1:0]                 acc_p_data,
  input  logic                                 acc_p_error,
  input  logic                                 acc_p_valid,
  output logic                                 acc_p_ready,
  output logic [cnt_width(MaxOutstanding)-1:0] outstanding_o,
  output logic                                 protocol_err_o
);

  localparam int unsigned OW    = cnt_width(MaxOutstanding);
  localparam int unsigned REQ_W = req_width(AddrWidth, IdWidth, DataWidth);
  localparam int unsigned IDE_W = id_entry_width(IdWidth);

  typedef struct packed {
    logic [AddrWidth-1:0]     addr;
    logic [IdWidth-1:0]       id;
    logic [INSTR_W-1:0]       instr;
    logic [3*DataWidth-1:0]   arg;
  } req_t;

  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic               local_err;
  } id_entry_t;

  req_t      w_req_in, w_req_head;
  id_entry_t w_ide_in, w_ide_head;
  logic      w_req_full, w_req_empty, w_req_pop;
  logic      w_ide_full, w_ide_empty, w_ide_pop;
  logic      w_addr_miss, w_rsp_free, w_acc_hs, w_load_acc, w_load_local;
  logic      w_slv_q_hs, w_slv_p_hs;
  logic      w_unused_bits;

  logic [OW-1:0]        r_outstanding;
  logic                 r_protocol_err;
  logic                 r_rsp_valid;
  logic [DataWidth-1:0] r_rsp_data;
  logic                 r_rsp_error;
  logic [IdWidth-1:0]   r_rsp_id;

  assign slv_q_ready = !rst_n && !w_req_full && (r_outstanding < OW'(MaxOutstanding));
  assign w_slv_q_hs  = slv_q_valid && slv_q_ready;
  assign w_req_in    = '{addr: slv_q_addr, id: slv_q_id, instr: slv_q_instr, arg: slv_q_arg};

  acc_adapter_fifo #(.WIDTH(REQ_W), .DEPTH(ReqDepth)) u_req_fifo (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .push  (w_slv_q_hs),
    .wdata (w_req_in),
    .pop   (w_req_pop),
    .rdata (w_req_head),
    .full  (w_req_full),
    .empty (w_req_empty)
  );

`ifdef ACC_C_SLV_ADAPTER_ADDR_CHECK_EN
  assign w_addr_miss = !w_req_empty && (w_req_head.addr[AccAddrWidth-1:0] != acc_addr_i);
`else
  assign w_addr_miss = 1'b0;
`endif
  assign w_unused_bits = ^{acc_addr_i, w_req_head.addr, w_ide_full};

  // Misrouted heads are retired locally so their error keeps its slot in order.
  assign acc_q_valid = !w_req_empty && !w_addr_miss;
  assign acc_q_instr = w_req_head.instr;
  assign acc_q_arg   = w_req_head.arg;
  assign w_req_pop   = !w_req_empty && (w_addr_miss || acc_q_ready);
  assign w_ide_in    = '{id: w_req_head.id, local_err: w_addr_miss};

  acc_adapter_fifo #(.WIDTH(IDE_W), .DEPTH(MaxOutstanding)) u_id_fifo (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .push  (w_req_pop),
    .wdata (w_ide_in),
    .pop   (w_ide_pop),
    .rdata (w_ide_head),
    .full  (w_ide_full),
    .empty (w_ide_empty)
  );

  // With no pending ID a stray response is swallowed rather than stalling the accelerator.
  assign w_rsp_free   = !r_rsp_valid || slv_p_ready;
  assign acc_p_ready  = !rst_n && (w_ide_empty || (!w_ide_head.local_err && w_rsp_free));
  assign w_acc_hs     = acc_p_valid && acc_p_ready;
  assign w_load_acc   = w_acc_hs && !w_ide_empty;
  assign w_load_local = !w_ide_empty && w_ide_head.local_err && w_rsp_free;
  assign w_ide_pop    = w_load_acc || w_load_local;
  assign w_slv_p_hs   = r_rsp_valid && slv_p_ready;

  always_ff @(posedge clk_i or posedge rst_n) begin
    if (rst_n) begin
      r_rsp_valid    <= 1'b0;
      r_rsp_data     <= '0;
      r_rsp_error    <= 1'b0;
      r_rsp_id       <= '0;
      r_protocol_err <= 1'b0;
      r_outstanding  <= '0;
    end else begin
      if (w_load_acc) begin
        r_rsp_valid <= 1'b1;
        r_rsp_data  <= acc_p_data;
        r_rsp_error <= acc_p_error;
        r_rsp_id    <= w_ide_head.id;
      end else if (w_load_local) begin
        r_rsp_valid <= 1'b1;
        r_rsp_data  <= '0;
        r_rsp_error <= 1'b1;
        r_rsp_id    <= w_ide_head.id;
      end else if (w_slv_p_hs) begin
        r_rsp_valid <= 1'b0;
      end
      if (w_acc_hs && w_ide_empty) r_protocol_err <= 1'b1;
      case ({w_slv_q_hs, w_slv_p_hs})
        2'b10:   r_outstanding <= r_outstanding + OW'(1);
        2'b01:   r_outstanding <= r_outstanding - OW'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  assign slv_p_valid    = r_rsp_valid;
  assign slv_p_data     = r_rsp_data;
  assign slv_p_error    = r_rsp_error;
  assign slv_p_id       = r_rsp_id;
  assign outstanding_o  = r_outstanding;
  assign protocol_err_o = r_protocol_err;

endmodule

`default_nettype wire

// File: tb/tb_acc_c_slv_adapter.sv
// Scoreboard bench for acc_c_slv_adapter: directed stimulus pushes expectations,
// negedge monitors pop and compare on every slv_p / acc_q handshake.
`default_nettype none

module tb_acc_c_slv_adapter;

  logic        clk_i = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  acc_addr_i;
  logic [5:0]  slv_q_addr;
  logic [3:0]  slv_q_id;
  logic [31:0] slv_q_instr;
  logic [95:0] slv_q_arg;
  logic        slv_q_valid;
  logic        slv_q_ready;
  logic [31:0] slv_p_data;
  logic        slv_p_error;
  logic [3:0]  slv_p_id;
  logic        slv_p_valid;
  logic        slv_p_ready;
  logic [31:0] acc_q_instr;
  logic [95:0] acc_q_arg;
  logic        acc_q_valid;
  logic        acc_q_ready;
  logic [31:0] acc_p_data;
  logic        acc_p_error;
  logic        acc_p_valid;
  logic        acc_p_ready;
  logic [2:0]  outstanding_o;
  logic        protocol_err_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [36:0] exp_rsp   [$];   // {id, error, data}
  logic [31:0] exp_instr [$];
  logic [36:0] e_rsp;
  logic [31:0] e_ins;

  always #5 clk_i = ~clk_i;

  acc_c_slv_adapter dut (
    .clk_i          (clk_i),
    .rst_n          (rst_n),
    .acc_addr_i     (acc_addr_i),
    .slv_q_addr     (slv_q_addr),
    .slv_q_id       (slv_q_id),
    .slv_q_instr    (slv_q_instr),
    .slv_q_arg      (slv_q_arg),
    .slv_q_valid    (slv_q_valid),
    .slv_q_ready    (slv_q_ready),
    .slv_p_data     (slv_p_data),
    .slv_p_error    (slv_p_error),
    .slv_p_id       (slv_p_id),
    .slv_p_valid    (slv_p_valid),
    .slv_p_ready    (slv_p_ready),
    .acc_q_instr    (acc_q_instr),
    .acc_q_arg      (acc_q_arg),
    .acc_q_valid    (acc_q_valid),
    .acc_q_ready    (acc_q_ready),
    .acc_p_data     (acc_p_data),
    .acc_p_error    (acc_p_error),
    .acc_p_valid    (acc_p_valid),
    .acc_p_ready    (acc_p_ready),
    .outstanding_o  (outstanding_o),
    .protocol_err_o (protocol_err_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: handshake timeout, got no handshake, expected one", name);
  endtask

  // Scoreboard monitors
  always @(negedge clk_i) begin
    if (!rst_n && slv_p_valid && slv_p_ready) begin
      if (exp_rsp.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL slv_p_unexpected: got id 0x%0h data 0x%0h, expected no response", slv_p_id, slv_p_data);
      end else begin
        e_rsp = exp_rsp.pop_front();
        chk("slv_p_rsp", {27'b0, slv_p_id, slv_p_error, slv_p_data}, {27'b0, e_rsp});
      end
    end
    if (!rst_n && acc_q_valid && acc_q_ready) begin
      if (exp_instr.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL acc_q_unexpected: got instr 0x%0h, expected no request", acc_q_instr);
      end else begin
        e_ins = exp_instr.pop_front();
        chk("acc_q_instr", {32'b0, acc_q_instr}, {32'b0, e_ins});
      end
    end
  end

  task automatic send_req(input logic [5:0] addr, input logic [3:0] id, input bit fwd);
    int n = 0;
    slv_q_addr  = addr;
    slv_q_id    = id;
    slv_q_instr = {16'hA5A5, 12'h000, id};
    slv_q_arg   = {32'h1, 32'h2, 28'h0, id};
    slv_q_valid = 1'b1;
    @(negedge clk_i);
    while (!slv_q_ready && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (!slv_q_ready) begin
      timeout("slv_q_accept");
      slv_q_valid = 1'b0;
    end else begin
      if (fwd) exp_instr.push_back({16'hA5A5, 12'h000, id});
      @(posedge clk_i);
      #1 slv_q_valid = 1'b0;
    end
  endtask

  task automatic wait_acc_hs();
    int n = 0;
    @(negedge clk_i);
    while (!acc_p_ready && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (!acc_p_ready) begin
      timeout("acc_p_accept");
      acc_p_valid = 1'b0;
    end else begin
      @(posedge clk_i);
      #1 acc_p_valid = 1'b0;
    end
  endtask

  task automatic acc_respond(input logic [31:0] d, input logic e);
    acc_p_data  = d;
    acc_p_error = e;
    acc_p_valid = 1'b1;
    wait_acc_hs();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    acc_addr_i  = 4'd3;
    slv_q_addr  = '0;
    slv_q_id    = '0;
    slv_q_instr = '0;
    slv_q_arg   = '0;
    slv_q_valid = 1'b0;
    slv_p_ready = 1'b1;
    acc_q_ready = 1'b0;
    acc_p_data  = '0;
    acc_p_error = 1'b0;
    acc_p_valid = 1'b0;

    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_slv_q_ready", slv_q_ready, 0);
    chk("rst_acc_q_valid", acc_q_valid, 0);
    chk("rst_acc_p_ready", acc_p_ready, 0);
    chk("rst_slv_p_valid", slv_p_valid, 0);
    chk("rst_slv_p_data", slv_p_data, 0);
    chk("rst_slv_p_error", slv_p_error, 0);
    chk("rst_slv_p_id", slv_p_id, 0);
    chk("rst_outstanding", outstanding_o, 0);
    chk("rst_protocol_err", protocol_err_o, 0);
    rst_n = 1'b0;
    @(posedge clk_i);
    #1;
    chk("post_rst_slv_q_ready", slv_q_ready, 1);

    // Single request, response 3 cycles later, slv_p one cycle after acc_p
    acc_q_ready = 1'b1;
    exp_rsp.push_back({4'd5, 1'b0, 32'hCAFE});
    send_req(6'd3, 4'd5, 1'b1);
    repeat (3) @(posedge clk_i);
    #1;
    acc_respond(32'hCAFE, 1'b0);
    chk("single_rsp_latency", slv_p_valid, 1);
    chk("single_rsp_id", slv_p_id, 5);
    @(posedge clk_i);
    #1;
    chk("single_outstanding", outstanding_o, 0);

    // Outstanding limit with ids 1..5
    for (int i = 1; i <= 5; i++) exp_rsp.push_back({i[3:0], 1'b0, 32'h1000 + i});
    for (int i = 1; i <= 4; i++) send_req(6'd3, i[3:0], 1'b1);
    chk("limit_outstanding", outstanding_o, 4);
    chk("limit_q_ready_low", slv_q_ready, 0);
    fork
      send_req(6'd3, 4'd5, 1'b1);
      begin
        repeat (2) @(posedge clk_i);
        #1;
        acc_respond(32'h1001, 1'b0);
        chk("limit_q_ready_held", slv_q_ready, 0);
        @(posedge clk_i);
        #1;
        chk("limit_q_ready_reenabled", slv_q_ready, 1);
        chk("limit_outstanding_dec", outstanding_o, 3);
      end
    join
    for (int i = 2; i <= 5; i++) acc_respond(32'h1000 + i, 1'b0);
    repeat (2) @(posedge clk_i);
    #1;
    chk("limit_drained", outstanding_o, 0);

    // Response backpressure
    exp_rsp.push_back({4'd6, 1'b0, 32'h66});
    exp_rsp.push_back({4'd7, 1'b0, 32'h77});
    send_req(6'd3, 4'd6, 1'b1);
    send_req(6'd3, 4'd7, 1'b1);
    slv_p_ready = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    acc_respond(32'h66, 1'b0);
    acc_p_data  = 32'h77;
    acc_p_valid = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      chk("bp_acc_p_ready_low", acc_p_ready, 0);
    end
    chk("bp_held_id", slv_p_id, 6);
    @(posedge clk_i);
    #1 slv_p_ready = 1'b1;
    wait_acc_hs();
    repeat (2) @(posedge clk_i);
    #1;
    chk("bp_drained", outstanding_o, 0);

    // Stray accelerator response
    chk("proto_err_clear", protocol_err_o, 0);
    acc_p_data  = 32'hDEAD;
    acc_p_valid = 1'b1;
    @(negedge clk_i);
    chk("proto_acc_p_ready", acc_p_ready, 1);
    @(posedge clk_i);
    #1 acc_p_valid = 1'b0;
    chk("proto_err_set", protocol_err_o, 1);
    chk("proto_no_rsp", slv_p_valid, 0);
    repeat (4) @(posedge clk_i);
    #1;
    chk("proto_err_sticky", protocol_err_o, 1);

    // Address routing
`ifdef ACC_C_SLV_ADAPTER_ADDR_CHECK_EN
    exp_rsp.push_back({4'd1, 1'b0, 32'hAB});
    exp_rsp.push_back({4'd2, 1'b1, 32'h0});
    send_req(6'd3, 4'd1, 1'b1);
    send_req(6'd7, 4'd2, 1'b0);
    repeat (3) @(posedge clk_i);
    #1;
    chk("addr_err_waits_for_id1", slv_p_valid, 0);
    acc_respond(32'hAB, 1'b0);
`else
    exp_rsp.push_back({4'd1, 1'b0, 32'hAB});
    exp_rsp.push_back({4'd2, 1'b0, 32'hBC});
    send_req(6'd3, 4'd1, 1'b1);
    send_req(6'd7, 4'd2, 1'b1);
    repeat (2) @(posedge clk_i);
    #1;
    acc_respond(32'hAB, 1'b0);
    acc_respond(32'hBC, 1'b0);
`endif
    repeat (3) @(posedge clk_i);
    #1;
    chk("addr_drained", outstanding_o, 0);

    // Reset with three outstanding
    send_req(6'd3, 4'd8, 1'b1);
    send_req(6'd3, 4'd9, 1'b1);
    send_req(6'd3, 4'd10, 1'b1);
    @(posedge clk_i);
    #1;
    chk("mid_outstanding", outstanding_o, 3);
    rst_n = 1'b1;
    #1;
    chk("mid_rst_slv_q_ready", slv_q_ready, 0);
    chk("mid_rst_acc_q_valid", acc_q_valid, 0);
    chk("mid_rst_acc_p_ready", acc_p_ready, 0);
    chk("mid_rst_slv_p_valid", slv_p_valid, 0);
    chk("mid_rst_outstanding", outstanding_o, 0);
    chk("mid_rst_protocol_err", protocol_err_o, 0);
    chk("mid_rst_slv_p_id", slv_p_id, 0);
    @(posedge clk_i);
    #1 rst_n = 1'b0;
    @(posedge clk_i);
    #1;
    chk("after_rst_outstanding", outstanding_o, 0);
    chk("after_rst_q_ready", slv_q_ready, 1);
    chk("after_rst_acc_q_valid", acc_q_valid, 0);
    repeat (5) @(posedge clk_i);
    #1;
    chk("after_rst_no_stale", slv_p_valid, 0);

    chk("rsp_queue_empty", exp_rsp.size(), 0);
    chk("instr_queue_empty", exp_instr.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
